// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC, imem handshake, exec hand-off, watchdog fault
module fetch_sequencer #(
   parameter logic [31:0] START_ADDR = 32'h00000000,
   parameter logic [7:0]  MAX_WAIT   = 8'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        ir_ena,
   output logic        exec_start,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] instr_count,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_EXEC  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  wait_q, wait_d;
   logic        start_q, start_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_REQ;
         end
         S_REQ: begin
            // An ack in the final allowed cycle still beats the timeout.
            if (imem_ack) begin
               wait_d  = 8'd0;
               start_d = 1'b1;
               state_d = S_EXEC;
            end else if (wait_q == MAX_WAIT - 8'd1) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d    = branch_taken ? branch_target : pc_q + 32'd4;
                  cnt_d   = cnt_q + 32'd1;
                  state_d = run ? S_REQ : S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= START_ADDR;
         cnt_q   <= 32'd0;
         wait_q  <= 8'd0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         start_q <= start_d;
      end
   end

   // ir_ena is the only Mealy output so IR loads on the ack edge itself.
   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = imem_req ? pc_q : 32'd0;
   assign ir_ena      = imem_req & imem_ack;
   assign exec_start  = start_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
   localparam logic [31:0] START = 32'hFFFFFFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic        imem_ack = 1'b0;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_req, ir_ena, exec_start, fault;
   logic [31:0] imem_addr, pc, instr_count;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          t0;
   logic [31:0] exp_fetch[$];
   logic [31:0] mon_exp;

   fetch_sequencer #(.START_ADDR(START), .MAX_WAIT(8'd4)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .ir_ena(ir_ena), .exec_start(exec_start), .exec_done(exec_done),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .instr_count(instr_count), .fault(fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every IR load must match the next expected fetch address.
   always @(negedge clk) begin
      if (ir_ena === 1'b1) begin
         if (exp_fetch.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_fetch: got addr %h expected no fetch", imem_addr);
         end else begin
            mon_exp = exp_fetch.pop_front();
            chk32("fetch_addr", imem_addr, mon_exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int delay, input logic [31:0] a);
      exp_fetch.push_back(a);
      for (int i = 0; i < delay; i++) begin
         imem_ack = 1'b0;
         #1;
         chk1("req_wait", imem_req, 1'b1);
         chk1("ir_ena_wait", ir_ena, 1'b0);
         step();
      end
      imem_ack = 1'b1;
      #1;
      chk1("req_ack", imem_req, 1'b1);
      step();
      imem_ack = 1'b0;
      chk1("exec_start", exec_start, 1'b1);
   endtask

   task automatic finish_exec(input logic br, input logic [31:0] tgt, input logic nrun);
      exec_done = 1'b1;
      branch_taken = br;
      branch_target = tgt;
      run = nrun;
      step();
      exec_done = 1'b0;
      branch_taken = 1'b0;
      branch_target = 32'd0;
   endtask

   task automatic check_reset();
      chk1("rst_imem_req", imem_req, 1'b0);
      chk1("rst_ir_ena", ir_ena, 1'b0);
      chk1("rst_exec_start", exec_start, 1'b0);
      chk1("rst_fault", fault, 1'b0);
      chk32("rst_imem_addr", imem_addr, 32'd0);
      chk32("rst_pc", pc, START);
      chk32("rst_instr_count", instr_count, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      step();
      step();
      check_reset();
      rst = 1'b1;
      step();
      chk1("idle_no_req", imem_req, 1'b0);

      // Zero-wait back-to-back, pc wraps from FFFFFFFC to 0.
      run = 1'b1;
      step();
      t0 = cyc;
      fetch(0, START);       finish_exec(1'b0, 32'd0, 1'b1);
      fetch(0, 32'h0);       finish_exec(1'b0, 32'd0, 1'b1);
      fetch(0, 32'h4);       finish_exec(1'b0, 32'd0, 1'b1);
      fetch(0, 32'h8);       finish_exec(1'b0, 32'd0, 1'b1);
      fetch(0, 32'hC);       finish_exec(1'b0, 32'd0, 1'b0);
      chk32("period_5_instr", 32'(cyc - t0), 32'd10);
      chk32("count_after_5", instr_count, 32'd5);
      chk32("pc_after_5", pc, 32'h10);
      chk1("idle_after_run_drop", imem_req, 1'b0);
      chk32("idle_addr_zero", imem_addr, 32'd0);

      // Ack on the last allowed REQ cycle, then branch, then run dropped during REQ.
      run = 1'b1;
      step();
      fetch(3, 32'h10);
      chk1("ack_wins_no_fault", fault, 1'b0);
      finish_exec(1'b1, 32'h100, 1'b1);
      fetch(1, 32'h100);
      finish_exec(1'b0, 32'd0, 1'b1);
      run = 1'b0;
      fetch(2, 32'h104);
      finish_exec(1'b0, 32'd0, 1'b0);
      chk1("idle_after_req_run_drop", imem_req, 1'b0);
      chk32("count_after_8", instr_count, 32'd8);
      chk32("pc_after_8", pc, 32'h108);

      // exec_done outside EXEC is ignored.
      exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h3;
      step();
      exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      chk1("idle_done_no_fault", fault, 1'b0);
      chk32("idle_done_pc", pc, 32'h108);
      chk32("idle_done_count", instr_count, 32'd8);

      // Timeout with MAX_WAIT=4.
      run = 1'b1;
      step();
      run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("timeout_req_held", imem_req, 1'b1);
         step();
      end
      chk1("timeout_fault", fault, 1'b1);
      chk1("timeout_req_off", imem_req, 1'b0);
      chk32("timeout_pc", pc, 32'h108);
      chk32("timeout_count", instr_count, 32'd8);
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("fault_sticky", fault, 1'b1);
         chk1("fault_no_req", imem_req, 1'b0);
      end
      imem_ack = 1'b0;

      // Reset out of FAULT, during REQ, and during EXEC.
      rst = 1'b0;
      step();
      check_reset();
      rst = 1'b1; run = 1'b1;
      step();
      run = 1'b0;
      chk1("req_before_reset", imem_req, 1'b1);
      rst = 1'b0;
      step();
      imem_ack = 1'b1;
      #1;
      check_reset();
      step();
      check_reset();
      imem_ack = 1'b0;
      rst = 1'b1; run = 1'b1;
      step();
      fetch(0, START);
      rst = 1'b0;
      step();
      check_reset();
      run = 1'b0; rst = 1'b1;
      step();

      // Misaligned branch target faults with pc and count frozen.
      run = 1'b1;
      step();
      fetch(0, START);
      finish_exec(1'b1, 32'h100, 1'b1);
      fetch(0, 32'h100);
      finish_exec(1'b1, 32'h102, 1'b1);
      chk1("misalign_fault", fault, 1'b1);
      chk32("misalign_pc", pc, 32'h100);
      chk32("misalign_count", instr_count, 32'd1);
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk1("misalign_no_req", imem_req, 1'b0);
         step();
      end
      imem_ack = 1'b0;
      run = 1'b0;

      chk32("scoreboard_empty", 32'(exp_fetch.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
